// File: rtl/trap_arbiter.sv
// M-stage trap arbiter: interrupt/exception prioritisation, delegation, WFI stall/timeout FSM.
// M outputs are combinational (0 cycles); W copies lag by one cycle and honour StallW/FlushW.
module trap_arbiter #(
    parameter int NINT        = 16,
    parameter int CAUSEW      = $clog2(NINT),
    parameter int S_SUPPORTED = 1,
    parameter int WFI_TIMEOUT = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InstrValidM,
    input  logic              CommittedM,
    input  logic              CommittedF,
    input  logic              InstrMisalignedFaultM,
    input  logic              InstrAccessFaultM,
    input  logic              HPTWInstrAccessFaultM,
    input  logic              IllegalInstrFaultM,
    input  logic              BreakpointFaultM,
    input  logic              LoadMisalignedFaultM,
    input  logic              StoreAmoMisalignedFaultM,
    input  logic              LoadAccessFaultM,
    input  logic              StoreAmoAccessFaultM,
    input  logic              EcallFaultM,
    input  logic              InstrPageFaultM,
    input  logic              LoadPageFaultM,
    input  logic              StoreAmoPageFaultM,
    input  logic              mretM,
    input  logic              sretM,
    input  logic              wfiM,
    input  logic [1:0]        PrivilegeModeW,
    input  logic [NINT-1:0]   MIP_REGW,
    input  logic [NINT-1:0]   MIE_REGW,
    input  logic [NINT-1:0]   MIDELEG_REGW,
    input  logic [15:0]       MEDELEG_REGW,
    input  logic              STATUS_MIE,
    input  logic              STATUS_SIE,
    input  logic              STATUS_TW,
    input  logic              StallW,
    input  logic              FlushW,
    output logic              TrapM,
    output logic              RetM,
    output logic              InterruptM,
    output logic              ExceptionM,
    output logic              IntPendingM,
    output logic              DelegateM,
    output logic [CAUSEW-1:0] CauseM,
    output logic              WFIStallM,
    output logic              TrapW,
    output logic              InterruptW,
    output logic              DelegateW,
    output logic [CAUSEW-1:0] CauseW
);

    localparam int CNTW = $clog2(WFI_TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LIM = CNTW'(WFI_TIMEOUT - 1);
    localparam bit S_EN = (S_SUPPORTED != 0);

    // Implemented lines: odd causes 1..13 plus every local line from 16 up.
    function automatic logic [NINT-1:0] impl_mask();
        logic [NINT-1:0] m;
        for (int i = 0; i < NINT; i++)
            m[i] = (i >= 16) || ((i % 2 == 1) && (i <= 13));
        return m;
    endfunction
    localparam logic [NINT-1:0] IMPL = impl_mask();

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t            state;
    logic [CNTW-1:0]   count;
    logic [NINT-1:0]   pending, enabled, valid_ints;
    logic              m_en, s_en, exc_src, wfi_timeout, tw_count_en, enter_wait;
    logic [CAUSEW-1:0] int_cause;
    logic [3:0]        exc_cause;

    assign pending     = MIP_REGW & MIE_REGW & IMPL;
    assign IntPendingM = |pending;
    assign m_en        = (PrivilegeModeW != 2'b11) | STATUS_MIE;
    assign s_en        = (PrivilegeModeW == 2'b00) | ((PrivilegeModeW == 2'b01) & STATUS_SIE);
    assign enabled     = ({NINT{m_en}} & pending & ~MIDELEG_REGW)
                       | ({NINT{s_en}} & pending & MIDELEG_REGW);
    assign valid_ints  = enabled & ~{NINT{CommittedM | CommittedF}};
    assign InterruptM  = (|valid_ints) & InstrValidM;

    assign exc_src = InstrMisalignedFaultM | InstrAccessFaultM | HPTWInstrAccessFaultM
                   | IllegalInstrFaultM | BreakpointFaultM | LoadMisalignedFaultM
                   | StoreAmoMisalignedFaultM | LoadAccessFaultM | StoreAmoAccessFaultM
                   | EcallFaultM | InstrPageFaultM | LoadPageFaultM | StoreAmoPageFaultM;

    // A wake or a flush in the limit cycle cancels the timeout trap.
    assign tw_count_en = STATUS_TW & (PrivilegeModeW != 2'b11);
    assign wfi_timeout = ~reset & (state == S_WAIT) & tw_count_en & (count == CNT_LIM)
                       & ~IntPendingM & ~FlushW;

    assign ExceptionM = exc_src | wfi_timeout;
    assign TrapM      = ExceptionM | InterruptM;
    assign RetM       = mretM | sretM;
    assign enter_wait = wfiM & InstrValidM & ~TrapM & ~IntPendingM;

    // Later assignments override earlier ones, so the fixed list runs lowest priority first.
    always_comb begin
        int_cause = '0;
        for (int i = NINT - 1; i >= 16; i--)
            if (valid_ints[i]) int_cause = CAUSEW'(i);
        if (valid_ints[13]) int_cause = CAUSEW'(13);
        if (valid_ints[5])  int_cause = CAUSEW'(5);
        if (valid_ints[1])  int_cause = CAUSEW'(1);
        if (valid_ints[9])  int_cause = CAUSEW'(9);
        if (valid_ints[7])  int_cause = CAUSEW'(7);
        if (valid_ints[3])  int_cause = CAUSEW'(3);
        if (valid_ints[11]) int_cause = CAUSEW'(11);
    end

    always_comb begin
        exc_cause = 4'd0;
        if (InstrPageFaultM)                                exc_cause = 4'd12;
        else if (InstrAccessFaultM | HPTWInstrAccessFaultM) exc_cause = 4'd1;
        else if (IllegalInstrFaultM | wfi_timeout)          exc_cause = 4'd2;
        else if (InstrMisalignedFaultM)                     exc_cause = 4'd0;
        else if (BreakpointFaultM)                          exc_cause = 4'd3;
        else if (EcallFaultM)                               exc_cause = {2'b10, PrivilegeModeW};
        else if (LoadMisalignedFaultM)                      exc_cause = 4'd4;
        else if (StoreAmoMisalignedFaultM)                  exc_cause = 4'd6;
        else if (LoadPageFaultM)                            exc_cause = 4'd13;
        else if (StoreAmoPageFaultM)                        exc_cause = 4'd15;
        else if (LoadAccessFaultM)                          exc_cause = 4'd5;
        else if (StoreAmoAccessFaultM)                      exc_cause = 4'd7;
    end

    assign CauseM    = reset ? '0 : (InterruptM ? int_cause : CAUSEW'(exc_cause));
    assign DelegateM = S_EN & ((PrivilegeModeW == 2'b00) | (PrivilegeModeW == 2'b01))
                     & (InterruptM ? MIDELEG_REGW[CauseM] : MEDELEG_REGW[CauseM[3:0]]);
    assign WFIStallM = ~reset & ((state == S_RUN) ? enter_wait
                                                  : (~IntPendingM & ~wfi_timeout & ~FlushW));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
            count <= '0;
        end else if (state == S_RUN) begin
            if (enter_wait) begin
                state <= S_WAIT;
                count <= '0;
            end
        end else if (IntPendingM | FlushW | wfi_timeout) begin
            state <= S_RUN;
        end else if (tw_count_en) begin
            count <= count + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset | FlushW) begin
            TrapW      <= 1'b0;
            InterruptW <= 1'b0;
            DelegateW  <= 1'b0;
            CauseW     <= '0;
        end else if (!StallW) begin
            TrapW      <= TrapM;
            InterruptW <= InterruptM;
            DelegateW  <= DelegateM;
            CauseW     <= CauseM;
        end
    end

endmodule

// File: tb/tb_trap_arbiter.sv
// Scoreboard bench for trap_arbiter: a 32-line/timeout-4 instance plus a 16-line instance
// without supervisor support that shares the same stimulus.
module tb_trap_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, InstrValidM, CommittedM, CommittedF;
    logic InstrMisalignedFaultM, InstrAccessFaultM, HPTWInstrAccessFaultM, IllegalInstrFaultM;
    logic BreakpointFaultM, LoadMisalignedFaultM, StoreAmoMisalignedFaultM, LoadAccessFaultM;
    logic StoreAmoAccessFaultM, EcallFaultM, InstrPageFaultM, LoadPageFaultM, StoreAmoPageFaultM;
    logic mretM, sretM, wfiM;
    logic [1:0]  PrivilegeModeW;
    logic [31:0] MIP_REGW, MIE_REGW, MIDELEG_REGW;
    logic [15:0] MEDELEG_REGW;
    logic STATUS_MIE, STATUS_SIE, STATUS_TW, StallW, FlushW;

    logic TrapM, RetM, InterruptM, ExceptionM, IntPendingM, DelegateM, WFIStallM;
    logic TrapW, InterruptW, DelegateW;
    logic [4:0] CauseM, CauseW;

    logic ns_TrapM, ns_RetM, ns_InterruptM, ns_ExceptionM, ns_IntPendingM, ns_DelegateM;
    logic ns_WFIStallM, ns_TrapW, ns_InterruptW, ns_DelegateW;
    logic [3:0] ns_CauseM, ns_CauseW;

    trap_arbiter #(.NINT(32), .S_SUPPORTED(1), .WFI_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .InstrValidM(InstrValidM),
        .CommittedM(CommittedM), .CommittedF(CommittedF),
        .InstrMisalignedFaultM(InstrMisalignedFaultM), .InstrAccessFaultM(InstrAccessFaultM),
        .HPTWInstrAccessFaultM(HPTWInstrAccessFaultM), .IllegalInstrFaultM(IllegalInstrFaultM),
        .BreakpointFaultM(BreakpointFaultM), .LoadMisalignedFaultM(LoadMisalignedFaultM),
        .StoreAmoMisalignedFaultM(StoreAmoMisalignedFaultM), .LoadAccessFaultM(LoadAccessFaultM),
        .StoreAmoAccessFaultM(StoreAmoAccessFaultM), .EcallFaultM(EcallFaultM),
        .InstrPageFaultM(InstrPageFaultM), .LoadPageFaultM(LoadPageFaultM),
        .StoreAmoPageFaultM(StoreAmoPageFaultM), .mretM(mretM), .sretM(sretM), .wfiM(wfiM),
        .PrivilegeModeW(PrivilegeModeW), .MIP_REGW(MIP_REGW), .MIE_REGW(MIE_REGW),
        .MIDELEG_REGW(MIDELEG_REGW), .MEDELEG_REGW(MEDELEG_REGW),
        .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE), .STATUS_TW(STATUS_TW),
        .StallW(StallW), .FlushW(FlushW),
        .TrapM(TrapM), .RetM(RetM), .InterruptM(InterruptM), .ExceptionM(ExceptionM),
        .IntPendingM(IntPendingM), .DelegateM(DelegateM), .CauseM(CauseM),
        .WFIStallM(WFIStallM), .TrapW(TrapW), .InterruptW(InterruptW),
        .DelegateW(DelegateW), .CauseW(CauseW)
    );

    trap_arbiter #(.NINT(16), .S_SUPPORTED(0), .WFI_TIMEOUT(100)) dut_ns (
        .clk(clk), .reset(reset), .InstrValidM(InstrValidM),
        .CommittedM(CommittedM), .CommittedF(CommittedF),
        .InstrMisalignedFaultM(InstrMisalignedFaultM), .InstrAccessFaultM(InstrAccessFaultM),
        .HPTWInstrAccessFaultM(HPTWInstrAccessFaultM), .IllegalInstrFaultM(IllegalInstrFaultM),
        .BreakpointFaultM(BreakpointFaultM), .LoadMisalignedFaultM(LoadMisalignedFaultM),
        .StoreAmoMisalignedFaultM(StoreAmoMisalignedFaultM), .LoadAccessFaultM(LoadAccessFaultM),
        .StoreAmoAccessFaultM(StoreAmoAccessFaultM), .EcallFaultM(EcallFaultM),
        .InstrPageFaultM(InstrPageFaultM), .LoadPageFaultM(LoadPageFaultM),
        .StoreAmoPageFaultM(StoreAmoPageFaultM), .mretM(mretM), .sretM(sretM), .wfiM(wfiM),
        .PrivilegeModeW(PrivilegeModeW), .MIP_REGW(MIP_REGW[15:0]), .MIE_REGW(MIE_REGW[15:0]),
        .MIDELEG_REGW(MIDELEG_REGW[15:0]), .MEDELEG_REGW(MEDELEG_REGW),
        .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE), .STATUS_TW(STATUS_TW),
        .StallW(StallW), .FlushW(FlushW),
        .TrapM(ns_TrapM), .RetM(ns_RetM), .InterruptM(ns_InterruptM), .ExceptionM(ns_ExceptionM),
        .IntPendingM(ns_IntPendingM), .DelegateM(ns_DelegateM), .CauseM(ns_CauseM),
        .WFIStallM(ns_WFIStallM), .TrapW(ns_TrapW), .InterruptW(ns_InterruptW),
        .DelegateW(ns_DelegateW), .CauseW(ns_CauseW)
    );

    typedef enum {F_TRAP, F_RET, F_INT, F_EXC, F_PEND, F_DEL, F_CAUSE, F_STALL,
                  F_TRAPW, F_INTW, F_DELW, F_CAUSEW, F_NS_DEL, F_NS_CAUSE} fld_e;
    typedef struct {
        fld_e        fld;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] actual(input fld_e f);
        case (f)
            F_TRAP:     return {31'd0, TrapM};
            F_RET:      return {31'd0, RetM};
            F_INT:      return {31'd0, InterruptM};
            F_EXC:      return {31'd0, ExceptionM};
            F_PEND:     return {31'd0, IntPendingM};
            F_DEL:      return {31'd0, DelegateM};
            F_CAUSE:    return {27'd0, CauseM};
            F_STALL:    return {31'd0, WFIStallM};
            F_TRAPW:    return {31'd0, TrapW};
            F_INTW:     return {31'd0, InterruptW};
            F_DELW:     return {31'd0, DelegateW};
            F_CAUSEW:   return {27'd0, CauseW};
            F_NS_DEL:   return {31'd0, ns_DelegateM};
            F_NS_CAUSE: return {28'd0, ns_CauseM};
            default:    return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: drains every expectation queued for the current cycle on the falling edge.
    initial begin
        exp_t e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.fld);
                checks++;
                if (a !== e.val) begin
                    failures++;
                    $display("FAIL %s: got %0d expected %0d at %0t", e.name, a, e.val, $time);
                end
            end
        end
    end

    task automatic push_exp(input fld_e f, input logic [31:0] v, input string nm);
        exp_t e;
        e.fld = f; e.val = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic check_now(input fld_e f, input logic [31:0] v, input string nm);
        logic [31:0] got;
        got = actual(f);
        checks++;
        if (got !== v) begin
            failures++;
            $display("FAIL(now) %s: got %0d expected %0d at %0t", nm, got, v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        InstrValidM = 1'b0; CommittedM = 1'b0; CommittedF = 1'b0;
        InstrMisalignedFaultM = 1'b0; InstrAccessFaultM = 1'b0; HPTWInstrAccessFaultM = 1'b0;
        IllegalInstrFaultM = 1'b0; BreakpointFaultM = 1'b0; LoadMisalignedFaultM = 1'b0;
        StoreAmoMisalignedFaultM = 1'b0; LoadAccessFaultM = 1'b0; StoreAmoAccessFaultM = 1'b0;
        EcallFaultM = 1'b0; InstrPageFaultM = 1'b0; LoadPageFaultM = 1'b0;
        StoreAmoPageFaultM = 1'b0; mretM = 1'b0; sretM = 1'b0; wfiM = 1'b0;
        PrivilegeModeW = 2'd3; MIP_REGW = '0; MIE_REGW = '0; MIDELEG_REGW = '0;
        MEDELEG_REGW = '0; STATUS_MIE = 1'b0; STATUS_SIE = 1'b0; STATUS_TW = 1'b0;
        StallW = 1'b0; FlushW = 1'b0;
    endtask

    task automatic set_ints(input logic [31:0] v);
        MIP_REGW = v; MIE_REGW = v;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        InstrValidM = 1'b1; IllegalInstrFaultM = 1'b1;
        step();
        check_now(F_CAUSE, 0, "reset_causem_now");
        check_now(F_STALL, 0, "reset_stall_now");
        check_now(F_TRAPW, 0, "reset_trapw_now");
        check_now(F_CAUSEW, 0, "reset_causew_now");
        push_exp(F_CAUSE, 0, "reset_causem");
        push_exp(F_STALL, 0, "reset_stall");
        push_exp(F_TRAPW, 0, "reset_trapw");
        push_exp(F_CAUSEW, 0, "reset_causew");
        step();
        reset = 1'b0; clear_inputs();
        push_exp(F_TRAPW, 0, "post_reset_trapw");
        push_exp(F_CAUSEW, 0, "post_reset_causew");

        // Machine interrupts 7 and 11: 11 wins, W copy follows a cycle later.
        step();
        InstrValidM = 1'b1; STATUS_MIE = 1'b1; set_ints(32'h0000_0880);
        push_exp(F_INT, 1, "m_int"); push_exp(F_CAUSE, 11, "m_cause11");
        push_exp(F_TRAP, 1, "m_trap"); push_exp(F_EXC, 0, "m_noexc");
        step();
        clear_inputs();
        push_exp(F_CAUSEW, 11, "w_cause11"); push_exp(F_TRAPW, 1, "w_trap");
        push_exp(F_INTW, 1, "w_int");

        // Local line priority and commit masking in user mode.
        step();
        InstrValidM = 1'b1; PrivilegeModeW = 2'd0; set_ints(32'h0003_0000);
        push_exp(F_CAUSE, 16, "local16");
        step(); set_ints(32'h0003_0020);
        push_exp(F_CAUSE, 5, "std5_over_local");
        step(); CommittedM = 1'b1;
        push_exp(F_INT, 0, "committed_noint"); push_exp(F_PEND, 1, "committed_pending");
        push_exp(F_TRAP, 0, "committed_notrap");
        step(); CommittedM = 1'b0; set_ints(32'h0001_2000);
        push_exp(F_CAUSE, 13, "c13_over_16");
        step(); set_ints(32'h0000_0022);
        push_exp(F_CAUSE, 1, "c1_over_5");
        step(); set_ints(32'h0000_0088);
        push_exp(F_CAUSE, 3, "c3_over_7");
        step(); set_ints(32'h0000_0004);
        push_exp(F_PEND, 0, "unimpl_masked"); push_exp(F_INT, 0, "unimpl_noint");

        // Supervisor delegation, with and without S support.
        step(); clear_inputs();
        InstrValidM = 1'b1; PrivilegeModeW = 2'd1; STATUS_SIE = 1'b1;
        MIDELEG_REGW = 32'h0000_0200; set_ints(32'h0000_0200);
        push_exp(F_CAUSE, 9, "s_cause9"); push_exp(F_DEL, 1, "s_deleg");
        push_exp(F_NS_CAUSE, 9, "ns_cause9"); push_exp(F_NS_DEL, 0, "ns_nodeleg");
        step(); clear_inputs();
        InstrValidM = 1'b1; PrivilegeModeW = 2'd0; EcallFaultM = 1'b1; MEDELEG_REGW = 16'h0100;
        push_exp(F_CAUSE, 8, "ecall_u"); push_exp(F_DEL, 1, "ecall_u_deleg");
        push_exp(F_EXC, 1, "ecall_exc"); push_exp(F_NS_DEL, 0, "ns_ecall_nodeleg");
        step(); PrivilegeModeW = 2'd3;
        push_exp(F_CAUSE, 11, "ecall_m"); push_exp(F_DEL, 0, "ecall_m_nodeleg");

        // Exception priority and interrupt-over-exception.
        step(); clear_inputs();
        InstrValidM = 1'b1; IllegalInstrFaultM = 1'b1; LoadPageFaultM = 1'b1;
        push_exp(F_CAUSE, 2, "illegal_over_ldpage");
        step(); InstrPageFaultM = 1'b1; StoreAmoAccessFaultM = 1'b1;
        push_exp(F_CAUSE, 12, "instrpage_top");
        step(); clear_inputs();
        InstrValidM = 1'b1; LoadPageFaultM = 1'b1; StoreAmoAccessFaultM = 1'b1;
        push_exp(F_CAUSE, 13, "ldpage_over_staccess");
        step(); clear_inputs();
        InstrValidM = 1'b1; STATUS_MIE = 1'b1; set_ints(32'h0000_0080); IllegalInstrFaultM = 1'b1;
        push_exp(F_INT, 1, "int_and_exc_int"); push_exp(F_EXC, 1, "int_and_exc_exc");
        push_exp(F_CAUSE, 7, "int_wins_cause");
        step(); clear_inputs(); mretM = 1'b1;
        push_exp(F_RET, 1, "mret"); push_exp(F_TRAP, 0, "mret_notrap");

        // WFI timeout in user mode with TW set.
        step(); clear_inputs();
        InstrValidM = 1'b1; PrivilegeModeW = 2'd0; STATUS_TW = 1'b1; wfiM = 1'b1;
        push_exp(F_STALL, 1, "wfi_to_entry"); push_exp(F_EXC, 0, "wfi_to_entry_noexc");
        for (int i = 1; i <= 3; i++) begin
            step();
            push_exp(F_STALL, 1, "wfi_to_wait"); push_exp(F_EXC, 0, "wfi_to_wait_noexc");
        end
        step();
        check_now(F_EXC, 1, "wfi_expired_exc_now");
        check_now(F_CAUSE, 2, "wfi_expired_cause_now");
        check_now(F_STALL, 0, "wfi_expired_stall_now");
        check_now(F_TRAP, 1, "wfi_expired_trap_now");
        push_exp(F_STALL, 0, "wfi_to_stall_drop"); push_exp(F_EXC, 1, "wfi_to_exc");
        push_exp(F_CAUSE, 2, "wfi_to_cause"); push_exp(F_TRAP, 1, "wfi_to_trap");
        step(); wfiM = 1'b0;
        push_exp(F_STALL, 0, "wfi_to_run"); push_exp(F_EXC, 0, "wfi_to_run_noexc");
        push_exp(F_TRAPW, 1, "wfi_to_trapw"); push_exp(F_CAUSEW, 2, "wfi_to_causew");

        // Wake in the would-be timeout cycle: no trap.
        step(); wfiM = 1'b1;
        push_exp(F_STALL, 1, "wake_entry");
        for (int i = 1; i <= 3; i++) begin
            step();
            push_exp(F_STALL, 1, "wake_wait");
        end
        step(); set_ints(32'h0000_0020);
        push_exp(F_STALL, 0, "wake_stall_drop"); push_exp(F_EXC, 0, "wake_noexc");
        push_exp(F_PEND, 1, "wake_pending");
        step(); clear_inputs();
        push_exp(F_STALL, 0, "wake_run");

        // WFI in M with interrupts globally disabled and TW set: no timeout, wake after 10.
        step();
        InstrValidM = 1'b1; STATUS_TW = 1'b1; wfiM = 1'b1;
        push_exp(F_STALL, 1, "mwfi_entry");
        for (int i = 1; i <= 9; i++) begin
            step();
            push_exp(F_STALL, 1, "mwfi_wait"); push_exp(F_EXC, 0, "mwfi_no_timeout");
        end
        step(); set_ints(32'h0000_0080);
        push_exp(F_STALL, 0, "mwfi_wake"); push_exp(F_INT, 0, "mwfi_noint");
        push_exp(F_TRAP, 0, "mwfi_notrap"); push_exp(F_PEND, 1, "mwfi_pending");
        step(); clear_inputs();

        // FlushW aborts the wait without a trap.
        step();
        InstrValidM = 1'b1; PrivilegeModeW = 2'd0; wfiM = 1'b1;
        push_exp(F_STALL, 1, "flush_entry");
        step(); FlushW = 1'b1;
        push_exp(F_EXC, 0, "flush_noexc");
        step(); FlushW = 1'b0; wfiM = 1'b0;
        push_exp(F_STALL, 0, "flush_run");

        // Reset in WAIT returns to RUN.
        step(); wfiM = 1'b1;
        push_exp(F_STALL, 1, "rstwait_entry");
        step();
        push_exp(F_STALL, 1, "rstwait_wait");
        step(); reset = 1'b1;
        push_exp(F_STALL, 0, "rstwait_reset_stall");
        step(); reset = 1'b0; wfiM = 1'b0;
        push_exp(F_STALL, 0, "rstwait_run"); push_exp(F_CAUSEW, 0, "rstwait_causew");

        // W register hold on StallW, clear on FlushW even while stalled.
        step(); clear_inputs();
        InstrValidM = 1'b1; STATUS_MIE = 1'b1; set_ints(32'h0000_0800);
        step(); clear_inputs();
        InstrValidM = 1'b1; IllegalInstrFaultM = 1'b1; StallW = 1'b1;
        push_exp(F_CAUSEW, 11, "wstall_load");
        step();
        push_exp(F_CAUSEW, 11, "wstall_hold");
        step(); FlushW = 1'b1;
        push_exp(F_CAUSEW, 11, "wstall_hold2");
        step(); clear_inputs();
        push_exp(F_CAUSEW, 0, "wflush_cause"); push_exp(F_TRAPW, 0, "wflush_trap");

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_arbiter.md
# trap_arbiter

Parametrised trap arbiter for the privileged unit. It generalises interrupt handling from the fixed 12 standard causes to NINT interrupt lines: standard, counter-overflow (13) and local/custom (16..NINT-1). It adds a WFI stall/timeout state machine and a registered W-stage copy of the trap decision for CSR update. It sits between the CSR file (mip/mie/mideleg/medeleg/mstatus) and the pipeline flush/PC-select logic, in the M stage.

## Interface
Parameters:
- NINT, 16 — number of interrupt lines; legal values 16, 32, 64.
- CAUSEW, $clog2(NINT) — width of cause outputs; must be ≥4.
- S_SUPPORTED, 1 — when 0, DelegateM/DelegateW are tied 0.
- WFI_TIMEOUT, 100 — cycles spent in WFI before a TW-induced illegal-instruction trap; range 1..2^16-1.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- InstrValidM  in  1  M-stage instruction valid, not flushed.
- CommittedM, CommittedF  in  1 each  LSU/IFU committed to an uninterruptible bus op.
- InstrMisalignedFaultM, InstrAccessFaultM, HPTWInstrAccessFaultM, IllegalInstrFaultM, BreakpointFaultM, LoadMisalignedFaultM, StoreAmoMisalignedFaultM, LoadAccessFaultM, StoreAmoAccessFaultM, EcallFaultM, InstrPageFaultM, LoadPageFaultM, StoreAmoPageFaultM  in  1 each  exception sources.
- mretM, sretM, wfiM  in  1 each  return / wait-for-interrupt in M.
- PrivilegeModeW  in  2  current privilege (M=3, S=1, U=0).
- MIP_REGW, MIE_REGW, MIDELEG_REGW  in  NINT  pending, enable, delegate.
- MEDELEG_REGW  in  16  exception delegation.
- STATUS_MIE, STATUS_SIE, STATUS_TW  in  1 each  global enables, timeout-wait.
- StallW, FlushW  in  1 each  W-stage register control.
- TrapM, RetM, InterruptM, ExceptionM, IntPendingM, DelegateM  out  1 each  combinational M-stage decision.
- CauseM  out  CAUSEW  combinational cause.
- WFIStallM  out  1  hold pipeline while waiting.
- TrapW, InterruptW, DelegateW  out  1 each  registered copies.
- CauseW  out  CAUSEW  registered cause.

## Operation
- Implemented interrupt bits: 1,3,5,7,9,11,13,16..NINT-1. All others are masked to 0 before any use.
- PendingInts = MIP & MIE & implemented mask; IntPendingM = |PendingInts, independent of global enables and Committed.
- Global enables: M-enable = (priv≠M) | STATUS_MIE; S-enable = (priv==U) | (priv==S & STATUS_SIE). Enabled = M-enable & Pending & ~MIDELEG | S-enable & Pending & MIDELEG.
- ValidInts = Enabled & ~(CommittedM|CommittedF). InterruptM = |ValidInts & InstrValidM.
- Interrupt priority, highest first: 11, 3, 7, 9, 1, 5, 13, then 16, 17, … NINT-1 (lower index wins).
- Exception priority follows interrupts: InstrPage 12, InstrAccess|HPTWInstrAccess 1, Illegal|WFITimeout 2, InstrMisaligned 0, Breakpoint 3, Ecall {2'b10,priv}, LoadMisaligned 4, StoreMisaligned 6, LoadPage 13, StorePage 15, LoadAccess 5, StoreAccess 7, else 0. Cause is zero-extended to CAUSEW. reset forces CauseM=0.
- ExceptionM = OR of all sources plus WFITimeout (internal). TrapM = ExceptionM | InterruptM. RetM = mretM | sretM.
- DelegateM = S_SUPPORTED & (priv∈{U,S}) & (InterruptM ? MIDELEG[CauseM] : MEDELEG[CauseM[3:0]]).
- WFI FSM, states RUN and WAIT:
  - RUN→WAIT when wfiM & InstrValidM & ~TrapM & ~IntPendingM. WFIStallM=1 in the entry cycle. The counter loads 0.
  - In WAIT, WFIStallM = ~IntPendingM. IntPendingM → RUN in the same cycle. The stall drops combinationally and the wfi retires as a nop; the interrupt is taken on a following instruction if globally enabled.
  - In WAIT, if STATUS_TW & priv≠M, the counter increments each cycle. When the count reaches WFI_TIMEOUT-1, WFITimeout=1 for that cycle: ExceptionM=1, CauseM=2, WFIStallM=0, next state RUN.
  - TW=0 or priv=M: no timeout; the counter holds.
  - FlushW in WAIT → RUN, no trap.
- W registers (TrapW, InterruptW, DelegateW, CauseW): load M values on ~StallW, clear on FlushW (FlushW wins over StallW).

## Timing
- M-stage outputs are combinational, zero latency. W outputs lag by 1 cycle.
- Reset: FSM=RUN, counter=0, TrapW=InterruptW=DelegateW=0, CauseW=0, WFIStallM=0. Reset mid-WAIT aborts the wait with no trap.
- Simultaneous interrupt and exception: interrupt wins, ExceptionM still reflects the sources.
- Simultaneous IntPendingM and timeout cycle: wake wins, no trap.
- Counter width ≥ $clog2(WFI_TIMEOUT+1). No wrap is possible, because the timeout exits at the limit.

## Test plan
- MIP=MIE=0x0880 (bits 7,11), priv=M, MIE=1, InstrValidM=1 → InterruptM=1, CauseM=11. Next cycle CauseW=11, TrapW=1.
- NINT=32, MIP=MIE=0x0003_0000, priv=U → CauseM=16. Add bit 5 → CauseM=5. Add CommittedM=1 → InterruptM=0, IntPendingM=1.
- Priv=S, MIDELEG bit 9 set, SIE=1, MIP/MIE bit 9 → DelegateM=1. Same with S_SUPPORTED=0 → DelegateM=0.
- wfiM in U, TW=1, WFI_TIMEOUT=4, no interrupts → WFIStallM high 4 cycles, then ExceptionM=1, CauseM=2, FSM=RUN.
- wfiM in M, MIE=0, MIP/MIE bit 7 asserted 10 cycles later → stall 10 cycles then drops, InterruptM=0 (global disable), TrapM=0.
- IllegalInstrFaultM with LoadPageFaultM → CauseM=2. Assert reset during WAIT → WFIStallM=0 and CauseW=0 next cycle.
